bep_decoder_param: RTL

Parametrised biphase-mark (BEP/BMC) line decoder, next generation of the single-rate fixed-delay decoder. Oversampled `digital_in` is synchronised, and edge-to-edge intervals are measured and classified as half-cell or full-cell. A lock FSM recovers bit cells and emits one-cycle-strobed decoded bits, with lock status and error reporting. It sits between the pad input and the downstream frame deserialiser.

---
 rtl/bep_decoder_param.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bep_decoder_param.sv
// bep_decoder_param
//   Biphase-mark (BMC) line decoder. The oversampled line is synchronised, the
//   spacing between line transitions is measured and classified as a half cell
//   or a full cell, and a small FSM rebuilds the bit cells. Once enough clean
//   cells have been seen in a row the decoder reports lock and starts emitting
//   bits.
//
//   Optional build macro: BEP_ERR_COUNT_EN adds the err_count output.
//
// Ports
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high
//   digital_in     in   asynchronous BMC line
//   decoded_data   out  last decoded bit, held between strobes
//   decoded_valid  out  one-cycle strobe, decoded_data is new
//   decoded_clock  out  recovered clock, high OVERSAMPLE/2 cycles from each strobe
//   locked         out  tracking with at least LOCK_CELLS good cells
//   error          out  one-cycle strobe on a coding or timing violation
//   err_count      out  (BEP_ERR_COUNT_EN only) saturating error count
//
// FSM states
//   state      | meaning
//   S_HUNT     | no reference edge yet; next edge starts a cell
//   S_BOUNDARY | last edge was a cell boundary
//   S_MID      | last edge was the mid-cell transition of a 1 bit
module bep_decoder_param #(
  parameter int OVERSAMPLE  = 8,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CELLS  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       digital_in,
  output logic       decoded_data,
  output logic       decoded_valid,
  output logic       decoded_clock,
  output logic       locked,
`ifdef BEP_ERR_COUNT_EN
  output logic       error,
  output logic [7:0] err_count
`else
  output logic       error
`endif
);

  localparam int CMAX = 2 * OVERSAMPLE;
  localparam int CW   = $clog2(2 * OVERSAMPLE + 1);
  localparam int HALF = OVERSAMPLE / 2;
  localparam int DW   = $clog2(HALF + 1);
  localparam int LW   = $clog2(LOCK_CELLS + 1);

  typedef enum logic [1:0] {
    S_HUNT     = 2'd0,
    S_BOUNDARY = 2'd1,
    S_MID      = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic                   locked_q, locked_d;
  logic                   valid_q, valid_d;
  logic                   data_q, data_d;
  logic                   error_q, error_d;
  logic [DW-1:0]          dclk_q, dclk_d;

  logic sync_out;
  logic edge_det;
  logic timeout;
  logic is_short;
  logic is_long;
  logic good;
  logic bit_val;
  int   t_int;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out ^ prev_q;
  assign timeout  = (cnt_q == CW'(CMAX));

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], digital_in};
    prev_d = sync_out;
    if (edge_det)     cnt_d = '0;
    else if (timeout) cnt_d = cnt_q;
    else              cnt_d = cnt_q + CW'(1);
  end

  // Interval ending at this edge, including the edge cycle itself.
  always_comb begin
    t_int    = int'(cnt_q) + 1;
    is_short = (t_int >= HALF - TOL) && (t_int <= HALF + TOL);
    is_long  = (t_int >= OVERSAMPLE - TOL) && (t_int <= OVERSAMPLE + TOL);
  end

  // When TOL makes the SHORT and LONG windows overlap, each state prefers
  // the interval it expects: a full cell at a boundary, a half cell mid-cell.
  always_comb begin
    state_d = state_q;
    good    = 1'b0;
    bit_val = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (edge_det) state_d = S_BOUNDARY;
      end
      S_BOUNDARY: begin
        if (edge_det) begin
          if (is_long)       good    = 1'b1;
          else if (is_short) state_d = S_MID;
          else               error_d = 1'b1;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_HUNT;
        end
      end
      S_MID: begin
        if (edge_det) begin
          state_d = S_BOUNDARY;
          if (is_short) begin
            good    = 1'b1;
            bit_val = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (error_d || (state_q == S_HUNT && edge_det))
      lock_cnt_d = '0;
    else if (good && lock_cnt_q != LW'(LOCK_CELLS))
      lock_cnt_d = lock_cnt_q + LW'(1);
    locked_d = (lock_cnt_d == LW'(LOCK_CELLS));

    // Only cells completed while already locked are passed downstream.
    valid_d = good && locked_q;
    data_d  = valid_d ? bit_val : data_q;

    if (error_d)            dclk_d = '0;
    else if (valid_d)       dclk_d = DW'(HALF);
    else if (dclk_q != '0)  dclk_d = dclk_q - DW'(1);
    else                    dclk_d = dclk_q;
  end

`ifdef BEP_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (error_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign err_count = err_cnt_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= S_HUNT;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      error_q    <= 1'b0;
      dclk_q     <= '0;
`ifdef BEP_ERR_COUNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      error_q    <= error_d;
      dclk_q     <= dclk_d;
`ifdef BEP_ERR_COUNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign decoded_data  = data_q;
  assign decoded_valid = valid_q;
  assign decoded_clock = (dclk_q != '0);
  assign locked        = locked_q;
  assign error         = error_q;

endmodule
